rw_put_state_pipe: RTL

//  Parametrised resumption-style state device: each "put" cycle writes input data into a

---
 rtl/rw_put_state_pipe_if.sv | 22 ++
 rtl/rw_put_state_pipe.sv | 85 ++++++++
 2 files changed

// File: rtl/rw_put_state_pipe_if.sv
// Put/flush bus for rw_put_state_pipe: data, put enable and flush in,
// delayed data, valid and sticky overflow out.
interface rw_put_state_pipe_if #(
    parameter int W = 1
);
    logic [W-1:0] __in0;
    logic         __in1;
    logic         __in2;
    logic [W-1:0] __out0;
    logic         __out1;
    logic         __out2;

    modport master (
        output __in0, __in1, __in2,
        input  __out0, __out1, __out2
    );

    modport slave (
        input  __in0, __in1, __in2,
        output __out0, __out1, __out2
    );
endinterface

// File: rtl/rw_put_state_pipe.sv
// DEPTH-deep put/echo state chain with optional running-sum front stage,
// fill/run resumption tag, synchronous flush and sticky add overflow.
//
// state | meaning
// FILL  | fewer than DEPTH puts since reset/flush; outputs report invalid
// RUN   | chain fully primed; last stage is presented on __out0
module rw_put_state_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1,
    parameter int MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    rw_put_state_pipe_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } tag_t;

    logic [W-1:0]  st     [DEPTH];
    logic [W-1:0]  st_nxt [DEPTH];
    tag_t          tag, tag_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ovf, ovf_nxt;
    logic [W:0]    sum_full;

    logic [W-1:0]  out0_q;
    logic          out1_q;
    logic          out2_q;

    always_comb begin
        st_nxt   = st;
        tag_nxt  = tag;
        cnt_nxt  = cnt;
        ovf_nxt  = ovf;
        sum_full = {1'b0, st[0]} + {1'b0, bus.__in0};
        if (bus.__in2) begin
            for (int i = 0; i < DEPTH; i++) st_nxt[i] = '0;
            tag_nxt = FILL;
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (bus.__in1) begin
            // accumulate mode keeps the running sum in stage 0, then delays it
            if (MODE == 1) begin
                st_nxt[0] = sum_full[W-1:0];
                ovf_nxt   = ovf | sum_full[W];
            end else begin
                st_nxt[0] = bus.__in0;
            end
            for (int i = 1; i < DEPTH; i++) st_nxt[i] = st[i-1];
            if (tag == FILL) begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(DEPTH - 1)) tag_nxt = RUN;
            end
        end
    end

    // outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= '0;
            tag    <= FILL;
            cnt    <= '0;
            ovf    <= 1'b0;
            out0_q <= '0;
            out1_q <= 1'b0;
            out2_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) st[i] <= st_nxt[i];
            tag    <= tag_nxt;
            cnt    <= cnt_nxt;
            ovf    <= ovf_nxt;
            out0_q <= (tag_nxt == RUN) ? st_nxt[DEPTH-1] : '0;
            out1_q <= (tag_nxt == RUN);
            out2_q <= ovf_nxt;
        end
    end

    assign bus.__out0 = out0_q;
    assign bus.__out1 = out1_q;
    assign bus.__out2 = out2_q;
endmodule
